// File: rtl/vga_capture_if.sv
// Pin and result bundle between a VGA source and the capture block.
// master drives the sync/colour pins and watches the results; slave is the capture side.
interface vga_capture_if;
  logic        h_sync;
  logic        v_sync;
  logic [3:0]  rgb_r;
  logic [3:0]  rgb_g;
  logic [3:0]  rgb_b;
  logic        pix_valid;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [11:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        err_h;
  logic        err_v;
  logic [7:0]  err_cnt;

  modport master (
    output h_sync, v_sync, rgb_r, rgb_g, rgb_b,
    input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_h, err_v, err_cnt
  );

  modport slave (
    input  h_sync, v_sync, rgb_r, rgb_g, rgb_b,
    output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_h, err_v, err_cnt
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel coordinates from sync pins, checks line/frame lengths
// against nominal timing and reports lock. Two cycles from pin to registered output.
module vga_capture #(
  parameter int H_SYNC  = 96,
  parameter int H_BLACK = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BLACK = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic         vga_clk,
  input  logic         rst,
  vga_capture_if.slave bus,
  output logic [1:0]   lock_state_dbg
);

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_LO    = 12'(H_SYNC + H_BLACK);
  localparam logic [11:0] H_HI    = 12'(H_SYNC + H_BLACK + H_ACT - 1);
  localparam logic [11:0] V_LO    = 12'(V_SYNC + V_BLACK);
  localparam logic [11:0] V_HI    = 12'(V_SYNC + V_BLACK + V_ACT - 1);
  localparam logic [11:0] X_OFS   = 12'(H_SYNC + H_BLACK - 1);
  localparam logic [11:0] Y_OFS   = 12'(V_SYNC + V_BLACK - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  logic        h1_q, hp_q, v1_q, vs_q;
  logic [11:0] rgb1_q;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vline_q, vline_d;
  logic        vs_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic        frame_bad_q, frame_bad_d;
  lock_state_e state_q, state_d;
  logic        ls, fs, active;
  logic        err_h_q, err_h_d, err_v_q, err_v_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_rgb_q, pix_rgb_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [8:0]  err_sum;

  // hcnt_d / vline_d are the coordinates of the sample currently held in stage 1.
  always_comb begin
    ls   = hp_q & ~h1_q;
    fs   = ls & vs_q & ~v1_q;
    vs_d = ls ? v1_q : vs_q;

    if (ls)                    hcnt_d = '0;
    else if (hcnt_q == CNT_MAX) hcnt_d = hcnt_q;
    else                       hcnt_d = hcnt_q + 12'd1;

    if (fs)                               vline_d = '0;
    else if (ls && (vline_q != CNT_MAX))  vline_d = vline_q + 12'd1;
    else                                  vline_d = vline_q;

    // Timeout fires only on the step into saturation, so it cannot repeat.
    err_h_d  = (ls & h_seen_q & (hcnt_q != H_LAST)) |
               (~ls & (hcnt_q == (CNT_MAX - 12'd1)));
    err_v_d  = fs & v_seen_q & (vline_q != V_LAST);
    h_seen_d = h_seen_q | ls;
    v_seen_d = v_seen_q | fs;
    frame_start_d = fs;
  end

  // An error coinciding with a frame start always blocks the promotion to LOCKED.
  always_comb begin
    state_d     = state_q;
    frame_bad_d = frame_bad_q;
    case (state_q)
      HUNT: begin
        if (fs) begin
          state_d     = CHECK;
          frame_bad_d = 1'b0;
        end
      end
      CHECK: begin
        if (fs) begin
          if (!frame_bad_q && !err_h_d && !err_v_d) state_d = LOCKED;
          frame_bad_d = 1'b0;
        end else if (err_h_d) begin
          frame_bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (err_h_d || err_v_d) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_comb begin
    active      = (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
                  (vline_d >= V_LO) && (vline_d <= V_HI);
    pix_valid_d = locked_d & active;
    pix_x_d     = pix_valid_d ? (hcnt_d - X_OFS) : 12'd0;
    pix_y_d     = pix_valid_d ? (vline_d - Y_OFS) : 12'd0;
    pix_rgb_d   = pix_valid_d ? rgb1_q : 12'd0;

    err_sum   = {1'b0, err_cnt_q} + {8'd0, err_h_q} + {8'd0, err_v_q};
    err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h1_q          <= 1'b0;
      hp_q          <= 1'b0;
      v1_q          <= 1'b0;
      vs_q          <= 1'b0;
      rgb1_q        <= '0;
      hcnt_q        <= '0;
      vline_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      state_q       <= HUNT;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      h1_q          <= bus.h_sync;
      hp_q          <= h1_q;
      v1_q          <= bus.v_sync;
      vs_q          <= vs_d;
      rgb1_q        <= {bus.rgb_r, bus.rgb_g, bus.rgb_b};
      hcnt_q        <= hcnt_d;
      vline_q       <= vline_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      frame_bad_q   <= frame_bad_d;
      state_q       <= state_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.pix_rgb     = pix_rgb_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = locked_q;
  assign bus.err_h       = err_h_q;
  assign bus.err_v       = err_v_q;
  assign bus.err_cnt     = err_cnt_q;
  assign lock_state_dbg  = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunken raster: every cycle is compared against a
// sample-level model of the recovery rules, plus per-scenario checks.
module tb_vga_capture;
  localparam int TH_SYNC = 4,  TH_BLACK = 3, TH_ACT = 16, TH_TOTAL = 28;
  localparam int TV_SYNC = 2,  TV_BLACK = 2, TV_ACT = 8,  TV_TOTAL = 14;
  localparam int REC_W = 49;
  localparam int S_HUNT = 0, S_CHECK = 1, S_LOCKED = 2;

  logic       vga_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] lock_state_dbg;

  vga_capture_if bus ();

  vga_capture #(
    .H_SYNC(TH_SYNC), .H_BLACK(TH_BLACK), .H_ACT(TH_ACT), .H_TOTAL(TH_TOTAL),
    .V_SYNC(TV_SYNC), .V_BLACK(TV_BLACK), .V_ACT(TV_ACT), .V_TOTAL(TV_TOTAL)
  ) dut (
    .vga_clk        (vga_clk),
    .rst            (rst),
    .bus            (bus),
    .lock_state_dbg (lock_state_dbg)
  );

  always #20 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;
  logic [REC_W-1:0] exp_q[$];

  // reference model state
  int m_prev_h, m_hc, m_vs, m_vl, m_hseen, m_vseen, m_state, m_bad, m_errs;

  // scenario monitor
  int n_fs, n_errh, n_errv, n_pv, n_lock_fall;
  int first_x, first_y, last_x, last_y, lock_rise_fs;
  logic [11:0] first_rgb;
  bit lock_fall_ok, errv_with_fs, prev_locked;

  task automatic model_reset();
    m_prev_h = 0; m_hc = 0; m_vs = 0; m_vl = 0;
    m_hseen = 0; m_vseen = 0; m_state = S_HUNT; m_bad = 0; m_errs = 0;
  endtask

  task automatic clear_mon();
    n_fs = 0; n_errh = 0; n_errv = 0; n_pv = 0; n_lock_fall = 0;
    first_x = 0; first_y = 0; last_x = 0; last_y = 0; first_rgb = '0;
    lock_rise_fs = -1; lock_fall_ok = 0; errv_with_fs = 0;
  endtask

  task automatic model_sample(input logic h, input logic v, input logic [11:0] rgb);
    bit ls, fs, eh, ev, valid;
    int x, y;
    logic [REC_W-1:0] rec;
    ls = (m_prev_h == 1) && (h == 1'b0);
    fs = 0; eh = 0; ev = 0;
    if (ls) begin
      if (m_hseen != 0 && m_hc != TH_TOTAL - 1) eh = 1;
      m_hseen = 1;
      fs = (m_vs == 1) && (v == 1'b0);
      m_vs = int'(v);
      if (fs) begin
        if (m_vseen != 0 && m_vl != TV_TOTAL - 1) ev = 1;
        m_vseen = 1;
        m_vl = 0;
      end else if (m_vl < 4095) m_vl++;
      m_hc = 0;
    end else begin
      if (m_hc == 4094) eh = 1;
      if (m_hc < 4095) m_hc++;
    end
    m_prev_h = int'(h);
    case (m_state)
      S_HUNT:  if (fs) begin m_state = S_CHECK; m_bad = 0; end
      S_CHECK: begin
        if (eh) m_bad = 1;
        if (fs) begin
          if (m_bad == 0 && !ev) m_state = S_LOCKED;
          m_bad = 0;
        end
      end
      default: if (eh || ev) m_state = S_HUNT;
    endcase
    valid = (m_state == S_LOCKED) &&
            m_hc >= TH_SYNC + TH_BLACK && m_hc < TH_SYNC + TH_BLACK + TH_ACT &&
            m_vl >= TV_SYNC + TV_BLACK && m_vl < TV_SYNC + TV_BLACK + TV_ACT;
    x = valid ? m_hc - TH_SYNC - TH_BLACK + 1 : 0;
    y = valid ? m_vl - TV_SYNC - TV_BLACK + 1 : 0;
    rec = {valid, 12'(x), 12'(y), (valid ? rgb : 12'h000), fs,
           (m_state == S_LOCKED), eh, ev, 8'(m_errs)};
    exp_q.push_back(rec);
    m_errs = m_errs + int'(eh) + int'(ev);
    if (m_errs > 255) m_errs = 255;
  endtask

  task automatic cycle(input logic h, input logic v, input logic [11:0] rgb);
    logic [REC_W-1:0] e, g;
    bus.h_sync = h;
    bus.v_sync = v;
    {bus.rgb_r, bus.rgb_g, bus.rgb_b} = rgb;
    model_sample(h, v, rgb);
    @(posedge vga_clk);
    #1;
    g = {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.frame_start,
         bus.locked, bus.err_h, bus.err_v, bus.err_cnt};
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL stream t=%0t got pv=%0b x=%0d y=%0d rgb=%h fs=%0b lk=%0b eh=%0b ev=%0b cnt=%0d required pv=%0b x=%0d y=%0d rgb=%h fs=%0b lk=%0b eh=%0b ev=%0b cnt=%0d",
                 $time, g[48], g[47:36], g[35:24], g[23:12], g[11], g[10], g[9], g[8], g[7:0],
                 e[48], e[47:36], e[35:24], e[23:12], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
    if (bus.frame_start) n_fs++;
    if (bus.err_h) n_errh++;
    if (bus.err_v) n_errv++;
    if (bus.err_v && bus.frame_start) errv_with_fs = 1;
    if (bus.pix_valid) begin
      if (n_pv == 0) begin first_x = bus.pix_x; first_y = bus.pix_y; first_rgb = bus.pix_rgb; end
      last_x = bus.pix_x; last_y = bus.pix_y;
      n_pv++;
    end
    if (bus.locked && !prev_locked) lock_rise_fs = bus.frame_start ? n_fs : -1;
    if (!bus.locked && prev_locked) begin
      n_lock_fall++;
      lock_fall_ok = bus.err_h || bus.err_v;
    end
    prev_locked = bus.locked;
  endtask

  task automatic do_reset(input logic h, input logic v, input logic [11:0] rgb);
    logic [REC_W+1:0] g;
    bus.h_sync = h;
    bus.v_sync = v;
    {bus.rgb_r, bus.rgb_g, bus.rgb_b} = rgb;
    rst = 1'b1;
    @(posedge vga_clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    g = {lock_state_dbg, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.frame_start,
         bus.locked, bus.err_h, bus.err_v, bus.err_cnt};
    checks++;
    if (g !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", g);
    end
    prev_locked = 0;
    clear_mon();
  endtask

  task automatic drive_line(input int len, input logic v, input int row, input int rst_at);
    for (int c = 0; c < len; c++) begin
      logic h;
      logic [11:0] rgb;
      int x;
      h = (c < TH_SYNC) ? 1'b0 : 1'b1;
      x = c - TH_SYNC - TH_BLACK + 1;
      if (x >= 1 && x <= TH_ACT && row >= 1 && row <= TV_ACT) rgb = {x[3:0], row[3:0], 4'hA};
      else rgb = 12'($urandom);
      if (c == rst_at) do_reset(h, v, rgb);
      else cycle(h, v, rgb);
    end
  endtask

  task automatic drive_frame(input int nlines, input int odd_line, input int odd_len,
                             input int rst_line, input int rst_cyc);
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == odd_line) ? odd_len : TH_TOTAL, (l < TV_SYNC) ? 1'b0 : 1'b1,
                 l - TV_SYNC - TV_BLACK + 1, (l == rst_line) ? rst_cyc : -1);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1, 12'h000);
  endtask

  task automatic test_nominal();
    clear_mon();
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    n_pv = 0;
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (lock_rise_fs !== 2) begin failures++; $display("FAIL nom_lock_fs got=%0d required=2", lock_rise_fs); end
    checks++; if (n_errh + n_errv !== 0) begin failures++; $display("FAIL nom_errors got=%0d required=0", n_errh + n_errv); end
    checks++; if (n_pv !== TH_ACT * TV_ACT) begin failures++; $display("FAIL nom_pix_count got=%0d required=%0d", n_pv, TH_ACT * TV_ACT); end
    checks++; if (first_x !== 1 || first_y !== 1) begin failures++; $display("FAIL nom_first_pix got=%0d/%0d required=1/1", first_x, first_y); end
    checks++; if (last_x !== TH_ACT || last_y !== TV_ACT) begin failures++; $display("FAIL nom_last_pix got=%0d/%0d required=%0d/%0d", last_x, last_y, TH_ACT, TV_ACT); end
    checks++; if (first_rgb !== 12'h11A) begin failures++; $display("FAIL nom_first_rgb got=%h required=11a", first_rgb); end
  endtask

  task automatic test_short_line();
    clear_mon();
    drive_frame(TV_TOTAL, 6, TH_TOTAL - 1, -1, 0);
    checks++; if (n_errh !== 1 || n_errv !== 0) begin failures++; $display("FAIL sl_err_pulses got=%0d/%0d required=1/0", n_errh, n_errv); end
    checks++; if (n_lock_fall !== 1 || !lock_fall_ok) begin failures++; $display("FAIL sl_unlock got=%0d/%0b required=1/1", n_lock_fall, lock_fall_ok); end
    checks++; if (bus.err_cnt !== 8'd1) begin failures++; $display("FAIL sl_err_cnt got=%0d required=1", bus.err_cnt); end
    clear_mon();
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (lock_rise_fs !== 2 || bus.locked !== 1'b1) begin failures++; $display("FAIL sl_relock got=%0d/%0b required=2/1", lock_rise_fs, bus.locked); end
  endtask

  task automatic test_short_frame();
    clear_mon();
    drive_frame(TV_TOTAL - 1, -1, 0, -1, 0);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (n_errv !== 1 || n_errh !== 0) begin failures++; $display("FAIL sf_err_pulses got=%0d/%0d required=1/0", n_errv, n_errh); end
    checks++; if (!errv_with_fs) begin failures++; $display("FAIL sf_fs_with_err got=0 required=1"); end
    checks++; if (n_lock_fall !== 1 || !lock_fall_ok || bus.locked !== 1'b0) begin failures++; $display("FAIL sf_unlock got=%0d/%0b/%0b required=1/1/0", n_lock_fall, lock_fall_ok, bus.locked); end
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL sf_relock got=%0b required=1", bus.locked); end
  endtask

  task automatic test_loss_of_sync();
    drive_frame(TV_TOTAL - 1, -1, 0, -1, 0);
    clear_mon();
    drive_line(5000, 1'b1, 0, -1);
    checks++; if (n_errh !== 1) begin failures++; $display("FAIL los_err_h got=%0d required=1", n_errh); end
    checks++; if (n_pv !== 0 || bus.locked !== 1'b0) begin failures++; $display("FAIL los_quiet got=%0d/%0b required=0/0", n_pv, bus.locked); end
    for (int f = 0; f < 3; f++) drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL los_relock got=%0b required=1", bus.locked); end
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(TV_TOTAL, -1, 0, 7, 10);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (n_errh + n_errv !== 0 || bus.err_cnt !== 8'd0) begin failures++; $display("FAIL rmf_errors got=%0d/%0d required=0/0", n_errh + n_errv, bus.err_cnt); end
    checks++; if (lock_rise_fs !== 2 || bus.locked !== 1'b1) begin failures++; $display("FAIL rmf_lock got=%0d/%0b required=2/1", lock_rise_fs, bus.locked); end
  endtask

  task automatic test_err_saturation();
    clear_mon();
    for (int i = 0; i < 300; i++) drive_line(TH_TOTAL - 1, 1'b1, 0, -1);
    drive_line(TH_TOTAL, 1'b1, 0, -1);
    checks++; if (n_errh !== 300) begin failures++; $display("FAIL sat_err_h got=%0d required=300", n_errh); end
    checks++; if (bus.err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_err_cnt got=%0d required=255", bus.err_cnt); end
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1, 12'h000);
    for (int f = 0; f < 6; f++) begin
      int nl, ol;
      nl = ($urandom_range(0, 2) == 0) ? $urandom_range(TV_TOTAL - 2, TV_TOTAL + 2) : TV_TOTAL;
      ol = ($urandom_range(0, 1) == 0) ? $urandom_range(0, nl - 1) : -1;
      drive_frame(nl, ol, $urandom_range(TH_SYNC + 2, 40), -1, 0);
    end
    for (int f = 0; f < 3; f++) drive_frame(TV_TOTAL, -1, 0, -1, 0);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL rnd_final_lock got=%0b required=1", bus.locked); end
  endtask

  initial begin
    model_reset();
    clear_mon();
    prev_locked = 0;
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_loss_of_sync();
    test_reset_mid_frame();
    test_err_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
# vga_capture

Receiver-side counterpart to the VGA timing generator. It samples the `h_sync`, `v_sync` and 4-bit RGB pins in the `vga_clk` domain, recovers 1-based pixel coordinates, checks line and frame lengths against the nominal timing, and reports lock. It is used for loopback self-test of the display path and as an on-chip monitor in front of a frame-capture buffer.

## Interface
- `H_SYNC`, 96: horizontal sync width, in clocks.
- `H_BLACK`, 48: horizontal back porch, in clocks.
- `H_ACT`, 640: active pixels per line.
- `H_TOTAL`, 800: clocks per line.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BLACK`, 33: vertical back porch, in lines.
- `V_ACT`, 480: active lines per frame.
- `V_TOTAL`, 525: lines per frame.
- `vga_clk` in 1: pixel clock, 25 MHz.
- `rst` in 1: reset. Synchronous, active-high.
- `h_sync` in 1: line sync, active-low pulse.
- `v_sync` in 1: frame sync, active-low.
- `rgb_r` / `rgb_g` / `rgb_b` in 4 each: pixel colour.
- `pix_valid` out 1: pixel strobe. High only while `locked` and inside the active window.
- `pix_x` out 12: column, 1..640. 0 when `pix_valid` is low.
- `pix_y` out 12: row, 1..480. 0 when `pix_valid` is low.
- `pix_rgb` out 12: `{r,g,b}` of the strobed pixel. 0 when `pix_valid` is low.
- `frame_start` out 1: one-cycle pulse at each detected frame start.
- `locked` out 1: timing verified.
- `err_h` out 1: one-cycle pulse on a line-length error.
- `err_v` out 1: one-cycle pulse on a frame-length error.
- `err_cnt` out 8: error count, saturating at 255. Counts `err_h` and `err_v` pulses.

## Operation
- **Stage 1.** Register `h_sync`, `v_sync` and RGB into `h1`, `v1`, `rgb1`. Keep the previous `h1` as `hp`; `hp` resets to 0.
- **Line start (LS).** `hp==1 && h1==0`.
- **Horizontal counter `hcnt` (12 bit).** On LS it loads 0. Otherwise it increments, saturating at 4095.
- **Line length check.** On LS, with `h_seen==1`: if `hcnt != H_TOTAL-1`, pulse `err_h`. Every LS sets `h_seen`.
- **Horizontal timeout.** `hcnt` reaching 4095 pulses `err_h` exactly once; the pulse is not repeated while `hcnt` stays saturated.
- **Vertical sample.** `v1` is sampled only at LS into `vs`; the previous sample is kept as `vsp`, which resets to 0.
- **Frame start (FS).** An LS where `vsp==1 && vs==0`. `frame_start` pulses on every FS, whether or not `locked` is set.
- **Line counter `vline` (12 bit).** On FS it loads 0. On any other LS it increments, saturating at 4095.
- **Frame length check.** On FS, with `v_seen==1`: if `vline != V_TOTAL-1`, pulse `err_v`. Every FS sets `v_seen`.
- **Active window.** `H_SYNC+H_BLACK <= hcnt <= H_SYNC+H_BLACK+H_ACT-1` and `V_SYNC+V_BLACK <= vline <= V_SYNC+V_BLACK+V_ACT-1`.
  - `pix_x = hcnt-H_SYNC-H_BLACK+1`
  - `pix_y = vline-V_SYNC-V_BLACK+1`
- **Lock FSM.**
  - HUNT → CHECK on FS; clear the `frame_bad` flag.
  - CHECK: any `err_h` sets `frame_bad`. On the next FS:
    - if `frame_bad==0` and no `err_v` is pulsed at that FS → LOCKED;
    - otherwise stay in CHECK and clear `frame_bad`.
  - LOCKED: any `err_h` or `err_v` → HUNT.
  - `locked` is 1 only in LOCKED.
- **Simultaneous events.** An error and an FS in the same cycle: the error wins.
  - In CHECK, the FSM stays in CHECK.
  - In LOCKED, the FSM goes to HUNT.
  - `frame_start` still pulses.
- **Reset.** Takes effect at the `vga_clk` edge with `rst==1`, including mid-frame. Every counter, flag and output goes to 0; the FSM goes to HUNT. The first LS and first FS after reset are never checked.

## Timing
- **Latency.** Exactly 2 cycles from pin to output: the pin sample taken k cycles after the first-low `h_sync` sample has `hcnt==k`, and its pixel outputs are registered one cycle after stage 1.
- **Alignment.** `pix_valid`, `pix_x`, `pix_y`, `pix_rgb`, `err_h`, `err_v` and `frame_start` are all registered and mutually aligned.
- **Lock timing.** With clean input, `locked` rises in the same cycle as the second `frame_start` after reset.
- **Unlock timing.** `locked` and `pix_valid` fall in the same cycle as the offending `err_h` or `err_v` pulse.
- **Error counter.** `err_cnt` updates one cycle after the error pulse.

## Test plan
- **Nominal lock.** Drive 3 frames of nominal 800×525 timing with `rgb = {x[3:0], y[3:0], 4'hA}` → `locked` rises at the 2nd `frame_start`, no errors, 307200 `pix_valid` pulses in frame 3, first pulse `pix_x=1` / `pix_y=1`, last pulse `640` / `480`, `pix_rgb` matches the drive.
- **Short line.** While locked, make one line 799 clocks → one `err_h` pulse, `locked` falls in the same cycle, `err_cnt=1`, relock at the 2nd FS that follows.
- **Short frame.** While locked, drop one line to give 524 lines → `err_v` pulse at the FS, `locked=0`, `frame_start` still pulses.
- **Loss of sync.** Hold `h_sync=1` for 5000 clocks → exactly one `err_h` at saturation, `pix_valid` stays 0.
- **Reset mid-frame.** Assert `rst` for 1 cycle at line 200 → all outputs 0 next cycle, no errors on the first partial line or frame, `locked` at the 2nd full FS.
- **Error counter saturation.** Inject 300 short lines → `err_cnt` stays at 255.
